// File: rtl/simple_ds_adc.sv
// Delta-sigma ADC front-end: comparator synchronizer/feedback plus a sinc^2 CIC
// decimator producing unsigned PCM samples with a one-cycle valid strobe.
module simple_ds_adc #(
  parameter int width      = 16,
  parameter int decim_log2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  output logic             fb_out,
  output logic [width-1:0] sample,
  output logic             sample_valid
);

  localparam int W  = 2 * decim_log2 + 1;
  localparam int SH = 2 * decim_log2 - width;

  logic                  s1_q, s1_d, s2_q, s2_d;
  logic [W-1:0]          i1_q, i1_d, i2_q, i2_d;
  logic [W-1:0]          i2_prev_q, i2_prev_d, d1_q, d1_d, d1_prev_q, d1_prev_d;
  logic [decim_log2-1:0] dec_cnt_q, dec_cnt_d;
  logic [1:0]            warm_q, warm_d;
  logic                  stage2_q, stage2_d;
  logic [width-1:0]      sample_q, sample_d;
  logic                  valid_q, valid_d;

  logic                    tick;
  logic [W-1:0]            r;
  logic [2*decim_log2-1:0] r_sat;

  always_comb begin
    s1_d      = bit_in;
    s2_d      = s1_q;
    i1_d      = i1_q + {{(W-1){1'b0}}, s2_q};
    i2_d      = i2_q + i1_q;
    dec_cnt_d = dec_cnt_q + 1'b1;
    i2_prev_d = i2_prev_q;
    d1_d      = d1_q;
    d1_prev_d = d1_prev_q;
    warm_d    = warm_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    r         = d1_q - d1_prev_q;
    // r can only reach R^2 (top bit set), which clamps to all ones
    r_sat     = r[W-1] ? '1 : r[2*decim_log2-1:0];

    tick     = (dec_cnt_q == {decim_log2{1'b1}});
    stage2_d = tick;

    if (tick) begin
      d1_d      = i2_q - i2_prev_q;
      i2_prev_d = i2_q;
      warm_d    = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;
    end

    // warm_q reaches 3 only from the third tick onward
    if (stage2_q) begin
      d1_prev_d = d1_q;
      sample_d  = width'(r_sat >> SH);
      valid_d   = (warm_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      i1_q      <= '0;
      i2_q      <= '0;
      i2_prev_q <= '0;
      d1_q      <= '0;
      d1_prev_q <= '0;
      dec_cnt_q <= '0;
      warm_q    <= '0;
      stage2_q  <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i2_prev_q <= i2_prev_d;
      d1_q      <= d1_d;
      d1_prev_q <= d1_prev_d;
      dec_cnt_q <= dec_cnt_d;
      warm_q    <= warm_d;
      stage2_q  <= stage2_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

  assign fb_out       = s2_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_simple_ds_adc.sv
// Bench for simple_ds_adc: expected samples come from a triangular-window
// weighted sum over the recorded input bitstream, not from integrator/comb math.
module tb_simple_ds_adc;

  localparam int R  = 256;
  localparam int R2 = 64;

  logic        clk;
  logic        rst, bit_in, fb_out, sample_valid;
  logic [15:0] sample;
  logic        rst2, bit_in2, fb_out2, sample_valid2;
  logic [11:0] sample2;

  int checks = 0;
  int errors = 0;
  int bin [0:4095];

  simple_ds_adc dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .fb_out(fb_out),
    .sample(sample), .sample_valid(sample_valid)
  );

  simple_ds_adc #(.width(12), .decim_log2(6)) dut2 (
    .clk(clk), .rst(rst2), .bit_in(bit_in2), .fb_out(fb_out2),
    .sample(sample2), .sample_valid(sample_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;     // 0 zeros, 1 ones, 2 alternating, 3 closed loop, 4 random
    int nstrobe;
    int exp;      // -1: no fixed target, model only
    int tol;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Input bit seen by the filter before edge p is bit_in driven for edge p-2.
  function automatic int model(input int e);
    int t, acc, p, xp, w;
    t   = e - 1;
    acc = 0;
    for (int j = 0; j <= 2*R-2; j++) begin
      p  = t - 2*R + j;
      xp = (p >= 2) ? bin[p-2] : 0;
      w  = (j + 1 < 2*R - 1 - j) ? j + 1 : 2*R - 1 - j;
      acc += w * xp;
    end
    if (acc > R*R - 1) acc = R*R - 1;
    return acc;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fb_out", fb_out, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_sample", sample, 0);
  endtask

  task automatic run(input int mode, input int nedges, input int exp, input int tol);
    int cur_exp, v, fbm, b, dens, exp_v, seen, want;
    cur_exp = 0;
    v       = 0;
    seen    = 0;
    want    = 0;
    dens    = $urandom_range(10, 90);
    for (int n = 0; n < nedges; n++) begin
      @(negedge clk);
      rst = 1'b0;
      case (mode)
        0: b = 0;
        1: b = 1;
        2: b = (n % 2 == 0) ? 1 : 0;
        3: begin
          fbm = (n >= 2) ? bin[n-2] : 0;
          v   = v + 1 - 4 * fbm;
          b   = (v > 0) ? 1 : 0;
        end
        default: b = ($urandom_range(0, 99) < dens) ? 1 : 0;
      endcase
      bit_in = b[0];
      bin[n] = b;
      @(posedge clk);
      #1;
      if (n >= 1) chk("fb_out", fb_out, bin[n-1]);
      else chk("fb_out", fb_out, 0);
      exp_v = (n % R == 0 && n >= 3*R) ? 1 : 0;
      chk("sample_valid", sample_valid, exp_v);
      if (n >= R && n % R == 0) cur_exp = model(n);
      chk("sample", sample, cur_exp);
      seen += int'(sample_valid);
      want += exp_v;
      if (exp_v == 1 && exp >= 0) begin
        checks++;
        if (int'(sample) > exp + tol || int'(sample) < exp - tol) begin
          errors++;
          $display("FAIL target mode %0d: got 0x%0h expected 0x%0h +/- 0x%0h", mode, sample, exp, tol);
        end
      end
    end
    chk("strobe_count", seen, want);
  endtask

  vec_t vecs [5];

  initial begin
    int exp_v2, seen2;
    vecs[0] = '{0, 4, 'h0000, 0};
    vecs[1] = '{1, 3, 'hFFFF, 0};
    vecs[2] = '{2, 3, 'h8000, 0};
    vecs[3] = '{3, 4, 'h4000, 'h100};
    vecs[4] = '{4, 3, -1, 0};

    rst = 1'b1; bit_in = 1'b0;
    rst2 = 1'b1; bit_in2 = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      run(vecs[i].mode, (vecs[i].nstrobe + 2) * R + 2, vecs[i].exp, vecs[i].tol);
    end

    // Reset pulse at edge 1000; afterwards warm-up must restart from zero.
    do_reset();
    run(4, 1000, -1, 0);
    @(negedge clk);
    rst = 1'b1;
    bit_in = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", sample_valid, 0);
    chk("midrst_fb_out", fb_out, 0);
    chk("midrst_sample", sample, 0);
    run(1, 3*R + 2, 'hFFFF, 0);

    // Non-default parameters: R = 64, 12-bit samples, all ones in.
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("p2_rst_valid", sample_valid2, 0);
    chk("p2_rst_sample", sample2, 0);
    seen2 = 0;
    for (int n = 0; n < 5*R2 + 2; n++) begin
      @(negedge clk);
      rst2 = 1'b0;
      bit_in2 = 1'b1;
      @(posedge clk);
      #1;
      exp_v2 = (n % R2 == 0 && n >= 3*R2) ? 1 : 0;
      chk("p2_valid", sample_valid2, exp_v2);
      if (n >= 1) chk("p2_fb_out", fb_out2, 1);
      if (exp_v2 == 1) chk("p2_sample", sample2, 'hFFF);
      seen2 += int'(sample_valid2);
    end
    chk("p2_strobe_count", seen2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
